// File: rtl/card_dealer.sv
// card_dealer
//
// Deals one card at a time from a single 52-card deck without repeating a
// card until the deck is renewed. On an accepted deal request the low six
// bits of the free-running game counter are used as a seed. The seed is
// folded into 0..51, and the deck is probed forward from that index (with
// wrap-around) until an undealt card is found.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high; clears all state and outputs
//   seed         counter value, sampled when deal_req is accepted
//   deal_req     request one card; only accepted while idle
//   new_deck     clear the dealt mask and abort any deal in progress
//   busy         high while probing or delivering
//   card_valid   one-cycle pulse; card outputs are valid
//   card_index   0..51, held until the next delivery
//   suit         card_index / 13
//   rank         (card_index mod 13) + 1
//   points       blackjack points for rank
//   is_ace       rank == 1
//   deck_empty   one-cycle pulse: request arrived with all 52 cards dealt
//   dealt_count  number of cards dealt, 0..52
//   dbg_state    current FSM state (0 idle, 1 probe, 2 deliver)
//
// Handshake: there is no back-pressure. A request is taken only on a cycle
// where the dealer is idle; requests while busy are dropped, not queued.
// card_valid is a single-cycle pulse and the card outputs stay stable
// afterwards until the next delivery, so the consumer may sample them at the
// pulse or any time later.

module card_dealer #(
    parameter int SEED_W    = 16,
    parameter int DECK_SIZE = 52
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEED_W-1:0] seed,
    input  logic              deal_req,
    input  logic              new_deck,
    output logic              busy,
    output logic              card_valid,
    output logic [5:0]        card_index,
    output logic [1:0]        suit,
    output logic [3:0]        rank,
    output logic [3:0]        points,
    output logic              is_ace,
    output logic              deck_empty,
    output logic [5:0]        dealt_count,
    output logic [1:0]        dbg_state
);

    localparam logic [5:0] LAST_IDX  = 6'(DECK_SIZE - 1);
    localparam logic [5:0] FULL_DECK = 6'(DECK_SIZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PROBE   = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t                 state;
    logic [DECK_SIZE-1:0]   mask;
    logic [5:0]             probe_idx;

    // Only the low six bits of the counter carry randomness we use.
    logic                   unused_seed_bits;
    assign unused_seed_bits = ^seed[SEED_W-1:6];

    logic [5:0] seed_low;
    logic [5:0] start_idx;
    logic [5:0] next_idx;
    logic [1:0] suit_c;
    logic [5:0] offset_c;
    logic [3:0] rank_c;
    logic [3:0] points_c;

    always_comb begin
        seed_low  = seed[5:0];
        // seed_low < 64, so a single subtraction lands it in 0..51.
        start_idx = (seed_low >= FULL_DECK) ? seed_low - FULL_DECK : seed_low;
        next_idx  = (probe_idx == LAST_IDX) ? 6'd0 : probe_idx + 6'd1;

        // Suit/rank by range comparison instead of a divider.
        suit_c   = 2'd0;
        offset_c = probe_idx;
        if (probe_idx >= 6'd39) begin
            suit_c   = 2'd3;
            offset_c = probe_idx - 6'd39;
        end else if (probe_idx >= 6'd26) begin
            suit_c   = 2'd2;
            offset_c = probe_idx - 6'd26;
        end else if (probe_idx >= 6'd13) begin
            suit_c   = 2'd1;
            offset_c = probe_idx - 6'd13;
        end
        rank_c = offset_c[3:0] + 4'd1;

        if (rank_c > 4'd10) begin
            points_c = 4'd10;
        end else begin
            points_c = rank_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mask        <= '0;
            probe_idx   <= 6'd0;
            dealt_count <= 6'd0;
            card_valid  <= 1'b0;
            deck_empty  <= 1'b0;
            card_index  <= 6'd0;
            suit        <= 2'd0;
            rank        <= 4'd0;
            points      <= 4'd0;
            is_ace      <= 1'b0;
        end else begin
            card_valid <= 1'b0;
            deck_empty <= 1'b0;
            if (new_deck) begin
                // Card outputs intentionally keep their last values.
                state       <= IDLE;
                mask        <= '0;
                dealt_count <= 6'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (deal_req) begin
                            if (dealt_count == FULL_DECK) begin
                                deck_empty <= 1'b1;
                            end else begin
                                probe_idx <= start_idx;
                                state     <= PROBE;
                            end
                        end
                    end
                    PROBE: begin
                        // Always terminates: entry requires an undealt card.
                        if (!mask[probe_idx]) begin
                            mask[probe_idx] <= 1'b1;
                            dealt_count     <= dealt_count + 6'd1;
                            card_index      <= probe_idx;
                            suit            <= suit_c;
                            rank            <= rank_c;
                            points          <= points_c;
                            is_ace          <= (rank_c == 4'd1);
                            card_valid      <= 1'b1;
                            state           <= DELIVER;
                        end else begin
                            probe_idx <= next_idx;
                        end
                    end
                    DELIVER: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: directed cases plus a randomized
// full-deck pass, all compared against a deck model kept as a plain array.

module tb_card_dealer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] seed;
    logic        deal_req;
    logic        new_deck;
    logic        busy;
    logic        card_valid;
    logic [5:0]  card_index;
    logic [1:0]  suit;
    logic [3:0]  rank;
    logic [3:0]  points;
    logic        is_ace;
    logic        deck_empty;
    logic [5:0]  dealt_count;
    logic [1:0]  dbg_state;

    card_dealer #(.SEED_W(16), .DECK_SIZE(52)) dut (
        .clk         (clk),
        .reset       (reset),
        .seed        (seed),
        .deal_req    (deal_req),
        .new_deck    (new_deck),
        .busy        (busy),
        .card_valid  (card_valid),
        .card_index  (card_index),
        .suit        (suit),
        .rank        (rank),
        .points      (points),
        .is_ace      (is_ace),
        .deck_empty  (deck_empty),
        .dealt_count (dealt_count),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model ----------------
    int checks = 0;
    int errors = 0;
    bit model_dealt[52];
    int model_count = 0;
    int seen[52];
    logic [5:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Index of the first undealt card at or after the seeded position, and
    // how many dealt cards were skipped on the way.
    function automatic int model_find(input logic [15:0] sd, output int skipped);
        int start;
        start = int'(sd[5:0]) % 52;
        for (int k = 0; k < 52; k++) begin
            if (!model_dealt[(start + k) % 52]) begin
                skipped = k;
                return (start + k) % 52;
            end
        end
        skipped = -1;
        return -1;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 52; i++) model_dealt[i] = 1'b0;
        model_count = 0;
    endfunction

    // ---------------- driver tasks ----------------
    // All tasks start and end at a falling edge with the dealer idle.
    task automatic do_deal(input logic [15:0] sd);
        int idx, k, lat, r, pts;
        logic [5:0] e;
        idx = model_find(sd, k);
        exp_q.push_back(6'(idx));
        deal_req = 1'b1;
        seed     = sd;
        @(negedge clk);
        deal_req = 1'b0;
        lat = 1;
        while (card_valid !== 1'b1 && lat < 120) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 2 + k);
        e   = exp_q.pop_front();
        r   = int'(e) % 13 + 1;
        pts = (r > 10) ? 10 : r;
        check("card_index", card_index, e);
        check("suit", suit, int'(e) / 13);
        check("rank", rank, r);
        check("points", points, pts);
        check("is_ace", is_ace, (r == 1) ? 1 : 0);
        model_dealt[idx] = 1'b1;
        model_count++;
        if (card_index < 6'd52) seen[card_index]++;
        check("dealt_count", dealt_count, model_count);
        check("busy_deliver", busy, 1);
        @(negedge clk);
        check("valid_pulse", card_valid, 0);
        check("busy_idle", busy, 0);
    endtask

    task automatic do_new_deck();
        new_deck = 1'b1;
        @(negedge clk);
        new_deck = 1'b0;
        model_clear();
        check("nd_count", dealt_count, 0);
        check("nd_busy", busy, 0);
    endtask

    task automatic try_empty();
        deal_req = 1'b1;
        seed     = 16'($urandom);
        @(negedge clk);
        deal_req = 1'b0;
        check("empty_pulse", deck_empty, 1);
        check("empty_no_valid", card_valid, 0);
        check("empty_busy", busy, 0);
        @(negedge clk);
        check("empty_pulse_end", deck_empty, 0);
        for (int i = 0; i < 4; i++) begin
            check("empty_no_valid_late", card_valid, 0);
            @(negedge clk);
        end
        check("empty_count", dealt_count, 52);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b1;
        deal_req = 1'b0;
        new_deck = 1'b0;
        seed     = 16'd0;
        model_clear();
        for (int i = 0; i < 52; i++) seen[i] = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_valid", card_valid, 0);
        check("rst_index", card_index, 0);
        check("rst_suit", suit, 0);
        check("rst_rank", rank, 0);
        check("rst_points", points, 0);
        check("rst_ace", is_ace, 0);
        check("rst_empty", deck_empty, 0);
        check("rst_count", dealt_count, 0);

        // Seed folding, ace, one-slot skip.
        do_deal(16'h0037);
        do_deal(16'h0040);
        do_deal(16'h0000);

        // Wrap from 51 back to 0.
        do_new_deck();
        do_deal(16'd51);
        do_deal(16'd51);

        // Face cards.
        do_new_deck();
        do_deal(16'd12);
        do_deal(16'd24);
        do_deal(16'd38);

        // new_deck and deal_req together: the request is dropped.
        deal_req = 1'b1;
        new_deck = 1'b1;
        seed     = 16'd5;
        @(negedge clk);
        deal_req = 1'b0;
        new_deck = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            check("both_no_valid", card_valid, 0);
            check("both_busy", busy, 0);
            @(negedge clk);
        end
        check("both_count", dealt_count, 0);

        // Long probe aborted by new_deck at cycle N+5.
        for (int i = 0; i < 40; i++) do_deal(16'(i));
        deal_req = 1'b1;
        seed     = 16'd0;
        @(negedge clk);
        deal_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("abort_busy", busy, 1);
            check("abort_no_valid", card_valid, 0);
            @(negedge clk);
        end
        new_deck = 1'b1;
        @(negedge clk);
        new_deck = 1'b0;
        model_clear();
        check("abort_count", dealt_count, 0);
        check("abort_busy_end", busy, 0);
        for (int i = 0; i < 3; i++) begin
            check("abort_no_valid_late", card_valid, 0);
            @(negedge clk);
        end
        do_deal(16'd7);

        // Reset in the middle of a probe.
        for (int i = 8; i < 20; i++) do_deal(16'(i));
        deal_req = 1'b1;
        seed     = 16'd7;
        @(negedge clk);
        deal_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        check("midrst_count", dealt_count, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rank", rank, 0);
        for (int i = 0; i < 3; i++) begin
            check("midrst_no_valid", card_valid, 0);
            @(negedge clk);
        end

        // Randomized full deck: every card exactly once, then empty.
        for (int i = 0; i < 52; i++) seen[i] = 0;
        for (int i = 0; i < 52; i++) do_deal(16'($urandom_range(0, 65535)));
        for (int i = 0; i < 52; i++) check("seen_once", seen[i], 1);
        check("full_count", dealt_count, 52);
        try_empty();

        // Fresh deck after full: dealing works again.
        do_new_deck();
        do_deal(16'($urandom_range(0, 65535)));

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
